tracking_fifo: RTL and testbench

//  Byte-wide 2048-entry FIFO between the host byte stream (FX2 side) and a converter stage such as the PMOD DAC driver.

---
 rtl/tracking_fifo_pkg.sv | 14 +
 rtl/tracking_fifo_if.sv | 21 ++
 rtl/tracking_fifo_bram_dp_2k8.sv | 26 ++
 rtl/tracking_fifo.sv | 110 +++++++++++
 tb/tb_tracking_fifo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tracking_fifo_pkg.sv
// Shared constants for the tracking FIFO and the PMOD DAC/ADC drivers that consume it.
// Also holds the saturating increment used by the underrun counter.
package tracking_fifo_pkg;

   localparam int          FIFO_ADDR_BITS = 11;
   localparam int          COUNT_WIDTH    = 32;
   localparam int          UNDERRUN_WIDTH = 16;
   localparam logic [7:0]  SILENCE_BYTE   = 8'h00;

   function automatic logic [UNDERRUN_WIDTH-1:0] sat_inc(input logic [UNDERRUN_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/tracking_fifo_if.sv
// Byte stream handshake between the host-side producer, the FIFO and its consumer.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface tracking_fifo_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       fifo_read;
   logic [7:0] fifo_data;

   modport master (
      output in_data, in_valid, fifo_read,
      input  in_ready, fifo_data
   );

   modport slave (
      input  in_data, in_valid, fifo_read,
      output in_ready, fifo_data
   );

endinterface

// File: rtl/tracking_fifo_bram_dp_2k8.sv
// Simple dual-port RAM: one write port, one registered read port; infers block RAM.
// The read register has no reset so the tools can pack it into the RAM primitive.
module bram_dp_2k8 #(
   parameter int ADDR_BITS = 11,
   parameter int DATA_W    = 8
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [DATA_W-1:0]    wdata_i,
   input  logic                 re_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output logic [DATA_W-1:0]    rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tracking_fifo.sv
// Byte FIFO with published pointers, occupancy and cumulative byte/underrun counters.
// Empty reads return silence through a zero-mux after the RAM, selected by a registered flag.
module tracking_fifo
   import tracking_fifo_pkg::*;
#(
   parameter int ADDR_BITS    = FIFO_ADDR_BITS,
   parameter int ALMOST_EMPTY = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   tracking_fifo_if.slave            bus,
   output logic [ADDR_BITS-1:0]      fifo_addr_in,
   output logic [ADDR_BITS-1:0]      fifo_addr_out,
   output logic [ADDR_BITS:0]        level,
   output logic                      empty,
   output logic                      almost_empty,
   output logic [COUNT_WIDTH-1:0]    write_fifo_byte_count,
   output logic [COUNT_WIDTH-1:0]    read_fifo_byte_count,
   output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

   logic [ADDR_BITS:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS:0]        rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
   logic [COUNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
   logic [UNDERRUN_WIDTH-1:0] ur_cnt_q, ur_cnt_d;
   logic                      silence_q, silence_d;
   logic                      full, wr_en, rd_en, underrun;
   logic [7:0]                ram_rdata;

   // Full/empty come from pre-edge pointers only, so a same-cycle write never feeds a read.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                     (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);
   assign wr_en    = bus.in_valid && !full && !flush;
   assign rd_en    = bus.fifo_read && !empty && !flush;
   assign underrun = bus.fifo_read && empty && !flush;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      ur_cnt_d  = ur_cnt_q;
      silence_d = silence_q;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         silence_d = 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_cnt_d  = rd_cnt_q + 1'b1;
            silence_d = 1'b0;
         end
         if (underrun) begin
            ur_cnt_d  = sat_inc(ur_cnt_q);
            silence_d = 1'b1;
         end
      end
   end

   // Silence flag resets high so fifo_data reads 0x00 without resetting the RAM register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         ur_cnt_q  <= '0;
         silence_q <= 1'b1;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         ur_cnt_q  <= ur_cnt_d;
         silence_q <= silence_d;
      end
   end

   bram_dp_2k8 #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_W    (8)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q[ADDR_BITS-1:0]),
      .wdata_i (bus.in_data),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q[ADDR_BITS-1:0]),
      .rdata_o (ram_rdata)
   );

   assign bus.fifo_data         = silence_q ? SILENCE_BYTE : ram_rdata;
   assign bus.in_ready          = !full;
   assign level                 = wr_ptr_q - rd_ptr_q;
   assign almost_empty          = (level < (ADDR_BITS+1)'(ALMOST_EMPTY));
   assign fifo_addr_in          = wr_ptr_q[ADDR_BITS-1:0];
   assign fifo_addr_out         = rd_ptr_q[ADDR_BITS-1:0];
   assign write_fifo_byte_count = wr_cnt_q;
   assign read_fifo_byte_count  = rd_cnt_q;
   assign underrun_count        = ur_cnt_q;

endmodule

// File: tb/tb_tracking_fifo.sv
// Bench for tracking_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_tracking_fifo;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [10:0] fifo_addr_in, fifo_addr_out;
   logic [11:0] level;
   logic        empty, almost_empty;
   logic [31:0] write_fifo_byte_count, read_fifo_byte_count;
   logic [15:0] underrun_count;

   tracking_fifo_if bus();

   tracking_fifo #(.ADDR_BITS(11), .ALMOST_EMPTY(8)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .flush                 (flush),
      .bus                   (bus),
      .fifo_addr_in          (fifo_addr_in),
      .fifo_addr_out         (fifo_addr_out),
      .level                 (level),
      .empty                 (empty),
      .almost_empty          (almost_empty),
      .write_fifo_byte_count (write_fifo_byte_count),
      .read_fifo_byte_count  (read_fifo_byte_count),
      .underrun_count        (underrun_count)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;

   // reference model state
   logic [7:0]  mq[$];
   int unsigned m_wc, m_rc;
   int          m_uc, m_wa, m_ra;
   logic [7:0]  m_data;
   int          wseq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_wc = 0; m_rc = 0; m_uc = 0; m_wa = 0; m_ra = 0; m_data = 8'h00;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic r, input logic f);
      bit was_empty, was_full;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      if (f) begin
         mq.delete();
         m_wa = 0; m_ra = 0; m_data = 8'h00;
      end else begin
         if (r) begin
            if (!was_empty) begin
               m_data = mq.pop_front();
               m_rc++;
               m_ra = (m_ra + 1) % DEPTH;
            end else begin
               m_data = 8'h00;
               if (m_uc < 65535) m_uc++;
            end
         end
         if (v && !was_full) begin
            mq.push_back(d);
            m_wc++;
            m_wa = (m_wa + 1) % DEPTH;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":data"},   bus.fifo_data,         m_data);
      chk({tag, ":level"},  level,                 mq.size());
      chk({tag, ":empty"},  empty,                 mq.size() == 0);
      chk({tag, ":aempty"}, almost_empty,          mq.size() < 8);
      chk({tag, ":ready"},  bus.in_ready,          mq.size() != DEPTH);
      chk({tag, ":waddr"},  fifo_addr_in,          m_wa);
      chk({tag, ":raddr"},  fifo_addr_out,         m_ra);
      chk({tag, ":wcnt"},   write_fifo_byte_count, m_wc);
      chk({tag, ":rcnt"},   read_fifo_byte_count,  m_rc);
      chk({tag, ":ucnt"},   underrun_count,        m_uc);
   endtask

   task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                        input logic r, input logic f);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.fifo_read = r;
      flush         = f;
      @(posedge clk);
      #1;
      model_step(v, d, r, f);
      bus.in_valid  = 1'b0;
      bus.fifo_read = 1'b0;
      flush         = 1'b0;
      check_all(tag);
   endtask

   initial begin
      int          guard;
      int          u0, ra0;
      int unsigned wc0, rc0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.fifo_read = 1'b0;
      flush         = 1'b0;
      wseq          = 0;
      reset         = 1'b0;
      model_reset();
      #22;
      check_all("reset");
      reset = 1'b1;

      // ordered write then read of 0x01..0x10
      for (int i = 1; i <= 16; i++) cycle("wr16", 1'b1, 8'(i), 1'b0, 1'b0);
      chk("wr16_level", level, 16);
      for (int i = 1; i <= 16; i++) begin
         cycle("rd16", 1'b0, 8'h00, 1'b1, 1'b0);
         chk("rd16_byte", bus.fifo_data, i);
      end
      chk("rd16_empty", empty, 1);
      chk("rd16_counts", {write_fifo_byte_count[15:0], read_fifo_byte_count[15:0]}, {16'd16, 16'd16});

      // fill to full, overflow write dropped, one read reopens
      for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("full_ready", bus.in_ready, 0);
      chk("full_level", level, 2048);
      cycle("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_wcnt", write_fifo_byte_count, 16 + 2048);
      cycle("ovf_rw", 1'b1, 8'hEF, 1'b1, 1'b0);
      chk("ovf_rw_level", level, 2047);
      chk("reopen_ready", bus.in_ready, 1);
      guard = 0;
      while (mq.size() != 0 && guard < 3000) begin
         cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
         guard++;
      end
      chk("drain_bound", guard < 3000, 1);

      // interleaved traffic: 3000 writes, wraps pointers
      wc0 = m_wc;
      guard = 0;
      while (m_wc - wc0 < 3000 && guard < 20000) begin
         logic v, r;
         v = ($urandom_range(0, 9) < 7);
         r = ($urandom_range(0, 9) < 6);
         cycle("mix", v, 8'(wseq), r, 1'b0);
         if (v && mq.size() > 0) wseq++;
         guard++;
      end
      chk("mix_bound", guard < 20000, 1);
      guard = 0;
      while (mq.size() != 0 && guard < 3000) begin
         cycle("mixdrain", 1'b0, 8'h00, 1'b1, 1'b0);
         guard++;
      end

      // five reads while empty, then write 0xAA with a same-cycle read
      u0  = m_uc;
      ra0 = m_ra;
      for (int i = 0; i < 5; i++) begin
         cycle("under", 1'b0, 8'h00, 1'b1, 1'b0);
         chk("under_zero", bus.fifo_data, 8'h00);
      end
      chk("under_cnt", underrun_count, u0 + 5);
      chk("under_addr", fifo_addr_out, ra0);
      cycle("aa_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
      chk("aa_cnt", underrun_count, u0 + 6);
      chk("aa_level", level, 1);
      cycle("aa_rd", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("aa_byte", bus.fifo_data, 8'hAA);

      // flush at level 100 with same-cycle write and read
      for (int i = 0; i < 100; i++) cycle("pre_fl", 1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle("pre_fl_rd", 1'b0, 8'h00, 1'b1, 1'b0);
      cycle("pre_fl_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
      chk("pre_fl_level", level, 100);
      wc0 = m_wc;
      rc0 = m_rc;
      u0  = m_uc;
      cycle("flush", 1'b1, 8'h77, 1'b1, 1'b1);
      chk("fl_level", level, 0);
      chk("fl_addrs", {fifo_addr_in, fifo_addr_out}, 22'd0);
      chk("fl_wcnt", write_fifo_byte_count, wc0);
      chk("fl_rcnt", read_fifo_byte_count, rc0);
      chk("fl_ucnt", underrun_count, u0);
      chk("fl_data", bus.fifo_data, 8'h00);

      // randomized traffic with occasional flush
      for (int i = 0; i < 3000; i++) begin
         logic v, r, f;
         v = ($urandom_range(0, 9) < 5);
         r = ($urandom_range(0, 9) < 5);
         f = ($urandom_range(0, 199) == 0);
         cycle("rand", v, 8'($urandom), r, f);
      end

      // asynchronous reset with 500 bytes queued and a read in flight
      cycle("pre_rst_fl", 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 500; i++) cycle("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle("pre_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
      cycle("pre_rst_w", 1'b1, 8'h33, 1'b0, 1'b0);
      chk("pre_rst_level", level, 500);
      bus.fifo_read = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      bus.fifo_read = 1'b0;
      #1;
      reset = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic v, r;
         v = ($urandom_range(0, 9) < 6);
         r = ($urandom_range(0, 9) < 4);
         cycle("post_rst", v, 8'($urandom), r, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
